// File: rtl/ct_l2cache_data_acc_ctrl_pkg.sv
// Shared definitions for the L2 data-RAM access controller: geometry, FSM encoding,
// the registered request record and the bank-mask-to-line expansion.
package ct_l2cache_data_acc_ctrl_pkg;

    localparam int L2C_DATA_INDEX_WIDTH = 10;
    localparam int L2C_DATA_BANK_NUM    = 4;
    localparam int L2C_DATA_BANK_WIDTH  = 128;
    localparam int L2C_DATA_LINE_WIDTH  = L2C_DATA_BANK_NUM * L2C_DATA_BANK_WIDTH;
    localparam int LAT_CNT_WIDTH        = $clog2(8);

    typedef logic [L2C_DATA_LINE_WIDTH-1:0] line_t;
    typedef logic [L2C_DATA_BANK_NUM-1:0]   bank_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } acc_state_e;

    typedef struct packed {
        logic       wr;
        bank_mask_t bank_mask;
        line_t      wdata;
    } req_t;

    function automatic line_t bank_mask_expand(input bank_mask_t mask);
        line_t m;
        m = '0;
        for (int b = 0; b < L2C_DATA_BANK_NUM; b++) begin
            m[b*L2C_DATA_BANK_WIDTH +: L2C_DATA_BANK_WIDTH] = {L2C_DATA_BANK_WIDTH{mask[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ct_l2cache_data_acc_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the
// data-RAM access controller (slave).
interface ct_l2cache_data_acc_ctrl_if
#(
    parameter int DATA_INDEX_LENTH = ct_l2cache_data_acc_ctrl_pkg::L2C_DATA_INDEX_WIDTH
);
    import ct_l2cache_data_acc_ctrl_pkg::*;

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_wr;
    bank_mask_t                  req_bank_mask;
    logic [DATA_INDEX_LENTH-1:0] req_index;
    line_t                       req_wdata;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic                        rsp_wr;
    line_t                       rsp_rdata;

    modport master (
        output req_valid, req_wr, req_bank_mask, req_index, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_wr, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_bank_mask, req_index, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_wr, rsp_rdata
    );

endinterface

// File: rtl/ct_l2cache_data_lat_cnt.sv
// Read-latency down-counter: load with RD_LATENCY, count down while dec, done on the last wait cycle.
// Latency: done is a combinational decode of the registered count.
// Backpressure: none; the caller decides when to load and decrement.
module ct_l2cache_data_lat_cnt
    import ct_l2cache_data_acc_ctrl_pkg::*;
#(
    parameter int RD_LATENCY = 2
)(
    input  logic forever_cpuclk,
    input  logic cpurst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam logic [LAT_CNT_WIDTH-1:0] LOAD_VAL = LAT_CNT_WIDTH'(RD_LATENCY);
    localparam logic [LAT_CNT_WIDTH-1:0] ONE      = LAT_CNT_WIDTH'(1);

    logic [LAT_CNT_WIDTH-1:0] cnt;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    // A count of one marks the cycle in which the RAM output is valid.
    assign done = (cnt == ONE);

endmodule

// File: rtl/ct_l2cache_data_acc_ctrl.sv
// L2 data-RAM access controller: one 4-bank access per request, read data captured and held as the response.
// Latency: handshake to rsp_valid is 2 cycles for writes/empty masks, RD_LATENCY+2 for reads.
// Backpressure: one request in flight; req_ready only in IDLE, RESP holds until rsp_ready.
module ct_l2cache_data_acc_ctrl
    import ct_l2cache_data_acc_ctrl_pkg::*;
#(
    parameter int DATA_INDEX_LENTH = L2C_DATA_INDEX_WIDTH,
    parameter int RD_LATENCY       = 2
)(
    input  logic                        forever_cpuclk,
    input  logic                        cpurst,
    ct_l2cache_data_acc_ctrl_if.slave   acc,
    output bank_mask_t                  l2c_data_ram_cen,
    output bank_mask_t                  l2c_data_wen,
    output logic [DATA_INDEX_LENTH-1:0] l2c_data_index0,
    output logic [DATA_INDEX_LENTH-1:0] l2c_data_index1,
    output logic [DATA_INDEX_LENTH-1:0] l2c_data_index2,
    output logic [DATA_INDEX_LENTH-1:0] l2c_data_index3,
    output line_t                       l2c_data_din,
    input  line_t                       l2c_data_dout
);

    acc_state_e                  state_q;
    acc_state_e                  state_d;
    req_t                        req_q;
    logic [DATA_INDEX_LENTH-1:0] index_q;
    logic                        rsp_wr_q;
    line_t                       rdata_q;
    logic                        hs;
    logic                        is_read;
    logic                        lat_load;
    logic                        lat_dec;
    logic                        lat_done;

    assign acc.req_ready = (state_q == ST_IDLE) && !cpurst;
    assign hs            = acc.req_valid && acc.req_ready;
    // Only reads that touch at least one bank need to wait for RAM data.
    assign is_read       = !req_q.wr && (req_q.bank_mask != '0);

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lat_load = 1'b0;
        lat_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (is_read) begin
                    state_d  = ST_WAIT;
                    lat_load = 1'b1;
                end else begin
                    state_d  = ST_RESP;
                end
            end
            ST_WAIT: begin
                lat_dec = 1'b1;
                if (lat_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (acc.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ct_l2cache_data_lat_cnt #(
        .RD_LATENCY (RD_LATENCY)
    ) u_lat_cnt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .load           (lat_load),
        .dec            (lat_dec),
        .done           (lat_done)
    );

    // rdata_q is both the read-capture register and the response hold register.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            req_q    <= '0;
            index_q  <= '0;
            rsp_wr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (hs) begin
                req_q   <= '{wr: acc.req_wr, bank_mask: acc.req_bank_mask, wdata: acc.req_wdata};
                index_q <= acc.req_index;
            end
            if (state_q == ST_ACCESS) begin
                rsp_wr_q <= req_q.wr;
                if (!is_read) rdata_q <= '0;
            end
            if ((state_q == ST_WAIT) && lat_done) begin
                rdata_q <= l2c_data_dout & bank_mask_expand(req_q.bank_mask);
            end
        end
    end

    assign l2c_data_ram_cen = (state_q == ST_ACCESS) ? ~req_q.bank_mask : 4'hF;
    assign l2c_data_wen     = (state_q == ST_ACCESS) ? ~({4{req_q.wr}} & req_q.bank_mask) : 4'hF;
    assign l2c_data_index0  = index_q;
    assign l2c_data_index1  = index_q;
    assign l2c_data_index2  = index_q;
    assign l2c_data_index3  = index_q;
    assign l2c_data_din     = req_q.wdata;

    assign acc.rsp_valid = (state_q == ST_RESP);
    assign acc.rsp_wr    = rsp_wr_q;
    assign acc.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ct_l2cache_data_acc_ctrl.sv
// Bench for the data-RAM access controller: three instances (RD_LATENCY 2, 1, 7),
// each with a behavioural 4-bank RAM whose output is garbage outside the exact read-data cycle.
module tb_ct_l2cache_data_acc_ctrl;
    import ct_l2cache_data_acc_ctrl_pkg::*;

    localparam int NDUT = 3;
    localparam int IW   = L2C_DATA_INDEX_WIDTH;
    localparam int NVEC = 8;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst       [NDUT];
    logic          req_valid [NDUT];
    logic          req_wr    [NDUT];
    logic [3:0]    req_mask  [NDUT];
    logic [IW-1:0] req_index [NDUT];
    line_t         req_wdata [NDUT];
    logic          rsp_ready [NDUT];

    logic          req_ready_o [NDUT];
    logic          rsp_valid_o [NDUT];
    logic          rsp_wr_o    [NDUT];
    line_t         rsp_rdata_o [NDUT];
    logic [3:0]    cen_o       [NDUT];
    logic [3:0]    wen_o       [NDUT];
    logic [4*IW-1:0] idx_o     [NDUT];
    line_t         din_o       [NDUT];

    logic [NDUT-1:0] rsp_fire;
    int              rsp_cnt [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        ct_l2cache_data_acc_ctrl_if #(.DATA_INDEX_LENTH(IW)) ifc ();

        logic [3:0]    cen;
        logic [3:0]    wen;
        logic [IW-1:0] ixb [4];
        line_t         din;
        line_t         dout;
        line_t         mem  [32];
        line_t         pipe [8];

        assign ifc.req_valid     = req_valid[d];
        assign ifc.req_wr        = req_wr[d];
        assign ifc.req_bank_mask = req_mask[d];
        assign ifc.req_index     = req_index[d];
        assign ifc.req_wdata     = req_wdata[d];
        assign ifc.rsp_ready     = rsp_ready[d];

        assign req_ready_o[d] = ifc.req_ready;
        assign rsp_valid_o[d] = ifc.rsp_valid;
        assign rsp_wr_o[d]    = ifc.rsp_wr;
        assign rsp_rdata_o[d] = ifc.rsp_rdata;
        assign cen_o[d]       = cen;
        assign wen_o[d]       = wen;
        assign idx_o[d]       = {ixb[3], ixb[2], ixb[1], ixb[0]};
        assign din_o[d]       = din;
        assign rsp_fire[d]    = !rst[d] && ifc.rsp_valid && rsp_ready[d];

        ct_l2cache_data_acc_ctrl #(
            .DATA_INDEX_LENTH (IW),
            .RD_LATENCY       (lat_of(d))
        ) u_dut (
            .forever_cpuclk   (clk),
            .cpurst           (rst[d]),
            .acc              (ifc),
            .l2c_data_ram_cen (cen),
            .l2c_data_wen     (wen),
            .l2c_data_index0  (ixb[0]),
            .l2c_data_index1  (ixb[1]),
            .l2c_data_index2  (ixb[2]),
            .l2c_data_index3  (ixb[3]),
            .l2c_data_din     (din),
            .l2c_data_dout    (dout)
        );

        // Line i starts as {16{0x1000_0000 | i}}; unread banks carry a per-cycle garbage word.
        always @(posedge clk) begin
            line_t rd;
            rd = {16{32'hBAD0_0000 ^ cyc}};
            if (cyc == 0) begin
                for (int i = 0; i < 32; i++) mem[i] <= {16{32'h1000_0000 | i}};
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (!cen[b]) begin
                        if (wen[b]) rd[b*128 +: 128] = mem[ixb[b][4:0]][b*128 +: 128];
                        else        mem[ixb[b][4:0]][b*128 +: 128] <= din[b*128 +: 128];
                    end
                end
            end
            pipe[0] <= rd;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end
        assign dout = pipe[lat_of(d)-1];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) if (rsp_fire[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
    end

    task automatic check(input string name, input int d, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
        end
    endtask

    // One request from the IDLE negedge through response and return to IDLE.
    // With hold_next, a second request (index ^ 1) is presented during the stall.
    task automatic do_txn(input int d, input logic wr, input logic [3:0] mask, input logic [IW-1:0] idx,
                          input line_t wdata, input line_t exp_rdata, input int stall, input logic hold_next);
        int         lat_exp;
        int         k;
        logic       cen_bad;
        logic       stall_bad;
        logic [3:0] e_cen;
        logic [3:0] e_wen;
        line_t      held;
        lat_exp = (wr || mask == 4'h0) ? 2 : lat_of(d) + 2;
        e_cen   = ~mask;
        e_wen   = ~({4{wr}} & mask);
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_mask[d]  = mask;
        req_index[d] = idx;
        req_wdata[d] = wdata;
        rsp_ready[d] = (stall == 0);
        #1;
        check("req_ready_idle", d, req_ready_o[d], 1'b1);
        @(posedge clk); @(negedge clk);
        req_valid[d] = 1'b0;
        check("cen_access", d, cen_o[d], e_cen);
        check("wen_access", d, wen_o[d], e_wen);
        check("index", d, idx_o[d], {4{idx}});
        if (wr) check("din", d, din_o[d], wdata);
        k = 1;
        cen_bad = 1'b0;
        while (!rsp_valid_o[d] && k < 20) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (cen_o[d] !== 4'hF || wen_o[d] !== 4'hF) cen_bad = 1'b1;
        end
        check("latency", d, k, lat_exp);
        check("cen_idle_between", d, cen_bad, 1'b0);
        check("rsp_wr", d, rsp_wr_o[d], wr);
        check("rsp_rdata", d, rsp_rdata_o[d], exp_rdata);
        held = rsp_rdata_o[d];
        stall_bad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (hold_next) begin
                req_valid[d] = 1'b1;
                req_index[d] = idx ^ IW'(1);
            end
            #1;
            if (!rsp_valid_o[d] || rsp_rdata_o[d] !== held || req_ready_o[d] !== 1'b0 || cen_o[d] !== 4'hF)
                stall_bad = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        if (stall > 0) check("stall_hold", d, stall_bad, 1'b0);
        rsp_ready[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        check("idle_after_rsp", d, {rsp_valid_o[d], req_ready_o[d]}, 2'b01);
    endtask

    typedef struct {
        logic          wr;
        logic [3:0]    mask;
        logic [IW-1:0] idx;
        line_t         wdata;
        line_t         exp_rdata;
    } vec_t;

    vec_t  vecs [NVEC];
    line_t junk;
    line_t wb;

    initial begin
        junk = {16{32'h5A5A_A5A5}};
        wb   = {{4{32'hBB33_0003}}, {4{32'hBB22_0002}}, {4{32'hBB11_0001}}, {4{32'hBB00_0000}}};
        vecs[0] = '{1'b0, 4'hF,    IW'(8'h15), junk, {16{32'h1000_0015}}};
        vecs[1] = '{1'b1, 4'b0101, IW'(8'h03), wb,   '0};
        vecs[2] = '{1'b0, 4'b0010, IW'(8'h07), junk, {256'h0, {4{32'h1000_0007}}, 128'h0}};
        vecs[3] = '{1'b0, 4'hF,    IW'(8'h03), junk,
                    {{4{32'h1000_0003}}, {4{32'hBB22_0002}}, {4{32'h1000_0003}}, {4{32'hBB00_0000}}}};
        vecs[4] = '{1'b1, 4'h0,    IW'(8'h04), {512{1'b1}}, '0};
        vecs[5] = '{1'b0, 4'hF,    IW'(8'h04), junk, {16{32'h1000_0004}}};
        vecs[6] = '{1'b0, 4'b1000, IW'(8'h1F), junk, {{4{32'h1000_001F}}, 384'h0}};
        vecs[7] = '{1'b0, 4'h0,    IW'(8'h02), junk, '0};

        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_mask[d] = '0;
            req_index[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1; rsp_cnt[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 0, req_ready_o[0], 1'b0);
        check("rst_cen", 0, cen_o[0], 4'hF);
        check("rst_wen", 0, wen_o[0], 4'hF);
        check("rst_rsp", 0, {rsp_valid_o[0], rsp_wr_o[0]}, 2'b00);
        check("rst_rdata", 0, rsp_rdata_o[0], '0);
        check("rst_index_din", 0, {idx_o[0], din_o[0]}, '0);
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;

        for (int d = 0; d < NDUT; d++) begin
            for (int v = 0; v < NVEC; v++) begin
                do_txn(d, vecs[v].wr, vecs[v].mask, vecs[v].idx, vecs[v].wdata, vecs[v].exp_rdata, 0, 1'b0);
            end
        end

        // Ten-cycle stall with the next request already waiting, then that request back-to-back.
        do_txn(0, 1'b0, 4'hF, IW'(8'h15), junk, {16{32'h1000_0015}}, 10, 1'b1);
        do_txn(0, 1'b0, 4'hF, IW'(8'h14), junk, {16{32'h1000_0014}}, 0, 1'b0);

        // Reset while in WAIT: everything returns to reset values and the read is dropped.
        req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_mask[0] = 4'hF; req_index[0] = IW'(8'h15); req_wdata[0] = junk;
        @(posedge clk); @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check("mid_rst_req_ready", 0, req_ready_o[0], 1'b0);
        @(posedge clk); @(negedge clk);
        check("mid_rst_cen_wen", 0, {cen_o[0], wen_o[0]}, 8'hFF);
        check("mid_rst_rsp", 0, {rsp_valid_o[0], rsp_wr_o[0]}, 2'b00);
        check("mid_rst_rdata", 0, rsp_rdata_o[0], '0);
        check("mid_rst_index_din", 0, {idx_o[0], din_o[0]}, '0);
        rst[0] = 1'b0;
        begin
            logic quiet_bad;
            quiet_bad = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); @(negedge clk);
                if (rsp_valid_o[0] || cen_o[0] !== 4'hF || !req_ready_o[0]) quiet_bad = 1'b1;
            end
            check("mid_rst_discard", 0, quiet_bad, 1'b0);
        end
        do_txn(0, 1'b0, 4'b0010, IW'(8'h07), junk, {256'h0, {4{32'h1000_0007}}, 128'h0}, 0, 1'b0);

        @(posedge clk); @(negedge clk);
        check("rsp_count", 0, rsp_cnt[0], NVEC + 3);
        check("rsp_count", 1, rsp_cnt[1], NVEC);
        check("rsp_count", 2, rsp_cnt[2], NVEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ct_l2cache_data_acc_ctrl.md
CT_L2CACHE_DATA_ACC_CTRL -- requirements
Module: ct_l2cache_data_acc_ctrl

Interface
REQ-001 Parameter DATA_INDEX_LENTH, default `L2C_DATA_INDEX_WIDTH, data RAM index width.
REQ-002 Parameter RD_LATENCY, default 2, clocks from RAM sampling edge to valid dout; legal range 1..7.
REQ-003 forever_cpuclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 cpurst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  access request.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_wr  in  1  1 = write, 0 = read.
REQ-008 req_bank_mask  in  4  banks to access; bit n = bank n, 128-bit slice n.
REQ-009 req_index  in  DATA_INDEX_LENTH  line index, sent to all banks.
REQ-010 req_wdata  in  512  write data.
REQ-011 rsp_valid  out  1  access complete.
REQ-012 rsp_ready  in  1  consumer accepts response.
REQ-013 rsp_wr  out  1  echo of req_wr.
REQ-014 rsp_rdata  out  512  read data; masked-off banks read as zero.
REQ-015 l2c_data_ram_cen  out  4  per-bank chip enable, active-low.
REQ-016 l2c_data_wen  out  4  per-bank write enable, active-low (0 = write).
REQ-017 l2c_data_index0..3  out  DATA_INDEX_LENTH each  per-bank index.
REQ-018 l2c_data_din  out  512  write data to banks.
REQ-019 l2c_data_dout  in  512  read data from banks.

Function
REQ-020 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready.
REQ-022 Handshake in cycle T: request fields registered; state -> ACCESS in T+1.
REQ-023 ACCESS, exactly one cycle: cen[n] = ~mask[n]; wen[n] = ~(req_wr & mask[n]); indices and din driven from registered request.
REQ-024 Outside ACCESS: cen = 4'hF, wen = 4'hF; index/din hold last value.
REQ-025 Read: ACCESS -> WAIT; down-counter loaded with RD_LATENCY, width $clog2(8); l2c_data_dout sampled in cycle T+1+RD_LATENCY for masked banks, then -> RESP.
REQ-026 Write, or mask = 4'h0: ACCESS -> RESP directly; rsp_rdata = 0.
REQ-027 RESP: rsp_valid = 1; rsp_wr and rsp_rdata stable until rsp_valid & rsp_ready; then -> IDLE.
REQ-028 rsp_ready held low: stay in RESP indefinitely; no new RAM access issued.
REQ-029 Read latency, handshake to rsp_valid: RD_LATENCY + 2 cycles; write: 2 cycles; min request spacing = latency + 1.
REQ-030 mask = 4'h0: request accepted, no cen asserted, response still returned.
REQ-031 req_valid while not IDLE: ignored; requester holds it.

Reset
REQ-032 cpurst sampled high: state = IDLE, cen = 4'hF, wen = 4'hF, rsp_valid = 0, rsp_wr = 0, rsp_rdata = 0, counter = 0, index/din = 0.
REQ-033 Reset mid-operation (ACCESS/WAIT/RESP): abort; no cen low in the cycle after reset; pending response discarded.
REQ-034 req_ready = 0 while cpurst = 1.

Structure
REQ-035 Shared package/define file: L2C_DATA_INDEX_WIDTH, FSM state encodings, bank count 4, bank width 128.
REQ-036 One sub-module, ct_l2cache_data_lat_cnt: RD_LATENCY down-counter with load/done.
REQ-037 Read-capture register and response hold register are shared (single 512-bit register).

Verification
REQ-038 Read, mask F, index 0x15, RD_LATENCY 2, dout = pattern A -> cen = 0 cycle 1 only, wen = F; rsp_valid cycle 4; rsp_rdata = A.
REQ-039 Write, mask 4'b0101, wdata B -> cycle 1: cen = 4'b1010, wen = 4'b1010, din = B; rsp_valid cycle 2, rsp_wr = 1.
REQ-040 Read, mask 4'b0010 -> rsp_rdata[255:128] = dout slice; all other bits 0.
REQ-041 rsp_ready low 10 cycles after read -> rsp_rdata stable, req_ready = 0, cen = F throughout; IDLE the cycle after rsp_ready.
REQ-042 cpurst asserted in WAIT -> next cycle all outputs at reset values; a new request is accepted afterwards with normal timing.
REQ-043 Sweep RD_LATENCY 1 and 7 with back-to-back requests -> latency per REQ-029; no lost or duplicated responses.
